// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative multiply/divide unit for a multicycle MIPS datapath.
//               Executes MULT, MULTU, DIV, DIVU with a shift-add multiplier
//               and a restoring shift-subtract divider, one bit per cycle,
//               then applies the sign correction and writes its own HI/LO.
//
// Ports       : clk          - clock, rising edge
//               rst          - asynchronous reset, active-low
//               start        - operation request, accepted only when idle
//               op           - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//               a            - operand A / dividend
//               b            - operand B / divisor
//               busy         - high while iterating or sign-fixing
//               done         - one-cycle pulse, hi/lo valid from this cycle
//               hi           - product high half / remainder
//               lo           - product low half / quotient
//               div_by_zero  - sticky per-operation divide-by-zero flag
//
// Build option: MULDIV_DIVZERO_FAST_EN
//               When defined, a divide by zero finishes one cycle after
//               accept and raises div_by_zero. When undefined, it runs the
//               full iteration, the override is applied at the sign-fix
//               step, and div_by_zero is held low.
//
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    // Operation context captured at accept
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;        // original signed dividend, for the div-by-zero result
    logic               r_a_sign;
    logic               r_b_sign;
    logic               r_dz;       // divide with a zero divisor
    logic [CW-1:0]      r_cnt;

    // Iteration datapath.
    // Multiply: r_acc = {partial sum, remaining multiplier bits}, r_opnd = |a|.
    // Divide  : r_acc[WIDTH-1:0] = dividend shifting out / quotient shifting in,
    //           r_rem = partial remainder, r_opnd = |b|.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_opnd;

    logic               w_accept;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH+1:0]   w_diff;
    logic [WIDTH:0]     w_rem_next;
    logic [WIDTH-1:0]   w_quot_next;
    logic               w_neg_res;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // ------------------------------------------------------------------
    // Operand conditioning: magnitudes only for the signed ops (op[0]=0)
    // ------------------------------------------------------------------
    assign w_accept = (r_state == S_IDLE) && start;
    assign w_abs_a  = (!op[0] && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign w_abs_b  = (!op[0] && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // ------------------------------------------------------------------
    // One multiply step: conditionally add multiplicand to the upper half,
    // then shift the whole accumulator right by one (carry enters the top).
    // ------------------------------------------------------------------
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // One restoring-divide step. The shifted remainder can reach nearly
    // twice the divisor, so the trial subtraction is one bit wider still
    // to keep a reliable borrow.
    // ------------------------------------------------------------------
    assign w_shift     = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
    assign w_diff      = {1'b0, w_shift} - {2'b00, r_opnd};
    assign w_rem_next  = w_diff[WIDTH+1] ? w_shift : w_diff[WIDTH:0];
    assign w_quot_next = {r_acc[WIDTH-2:0], ~w_diff[WIDTH+1]};

    // ------------------------------------------------------------------
    // Sign correction. Quotient/product negate on differing operand signs;
    // the remainder follows the dividend (truncation toward zero).
    // ------------------------------------------------------------------
    assign w_neg_res  = !r_op[0] && (r_a_sign ^ r_b_sign);
    assign w_prod_fix = w_neg_res ? (~r_acc + 1'b1) : r_acc;
    assign w_quot_fix = w_neg_res ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
    assign w_rem_fix  = (!r_op[0] && r_a_sign) ? (~r_rem[WIDTH-1:0] + 1'b1)
                                               : r_rem[WIDTH-1:0];

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
`ifdef MULDIV_DIVZERO_FAST_EN
                if (r_dz) begin
                    w_next = S_DONE;
                end else if (r_cnt == CW'(WIDTH - 1)) begin
                    w_next = S_FIX;
                end
`else
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_next = S_FIX;
                end
`endif
            end
            S_FIX: begin
                busy   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
`ifdef MULDIV_DIVZERO_FAST_EN
    logic r_dbz_flag;
    assign div_by_zero = r_dbz_flag;
`else
    assign div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op       <= 2'b00;
            r_a        <= '0;
            r_a_sign   <= 1'b0;
            r_b_sign   <= 1'b0;
            r_dz       <= 1'b0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_rem      <= '0;
            r_opnd     <= '0;
            hi         <= '0;
            lo         <= '0;
`ifdef MULDIV_DIVZERO_FAST_EN
            r_dbz_flag <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_op     <= op;
                r_a      <= a;
                r_a_sign <= !op[0] && a[WIDTH-1];
                r_b_sign <= !op[0] && b[WIDTH-1];
                r_dz     <= op[1] && (b == '0);
                r_cnt    <= '0;
                r_rem    <= '0;
                if (op[1]) begin
                    r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
                    r_opnd <= w_abs_b;
                end else begin
                    r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
                    r_opnd <= w_abs_a;
                end
`ifdef MULDIV_DIVZERO_FAST_EN
                r_dbz_flag <= 1'b0;
`endif
            end else if (r_state == S_CALC) begin
`ifdef MULDIV_DIVZERO_FAST_EN
                if (r_dz) begin
                    hi         <= r_a;
                    lo         <= '1;
                    r_dbz_flag <= 1'b1;
                end else
`endif
                begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_op[1]) begin
                        r_rem            <= w_rem_next;
                        r_acc[WIDTH-1:0] <= w_quot_next;
                    end else begin
                        r_acc <= w_mul_next;
                    end
                end
            end else if (r_state == S_FIX) begin
                if (r_op[1]) begin
                    if (r_dz) begin
                        hi <= r_a;
                        lo <= '1;
                    end else begin
                        hi <= w_rem_fix;
                        lo <= w_quot_fix;
                    end
                end else begin
                    hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                    lo <= w_prod_fix[WIDTH-1:0];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit. Expected values
//               are hand-computed constants; divide-by-zero timing follows
//               the MULDIV_DIVZERO_FAST_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int tests;
    int failed;
    int lat;
    int bcnt;
    int pulses;
    int first_done;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

`ifdef MULDIV_DIVZERO_FAST_EN
    localparam int          DZ_LAT = 1;
    localparam logic [31:0] DZ_FLAG = 32'd1;
`else
    localparam int          DZ_LAT = 33;
    localparam logic [31:0] DZ_FLAG = 32'd0;
`endif

    muldiv_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation, scramble the inputs right after accept, then
    // measure accept-to-done latency and the number of busy cycles.
    // Finishes by checking that done was a single-cycle pulse.
    task automatic do_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         output int latency, output int busy_cycles);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = ~o;
        a     = ~av;
        b     = 32'h5A5A_0F0F;
        latency     = 0;
        busy_cycles = 0;
        while (!done && latency < 100) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            latency++;
        end
        @(posedge clk);
        #1;
        check("done_single_pulse", {31'd0, done}, 32'd0);
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst    = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        a      = '0;
        b      = '0;

        // Reset state
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // MULTU max * max
        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
        check("multu_max_lat", lat, 32'd33);
        check("multu_max_hi", hi, 32'hFFFF_FFFE);
        check("multu_max_lo", lo, 32'h0000_0001);

        // MULT -3 * 7, busy exactly 33 cycles
        do_op(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, lat, bcnt);
        check("mult_neg_busy", bcnt, 32'd33);
        check("mult_neg_lat", lat, 32'd33);
        check("mult_neg_hi", hi, 32'hFFFF_FFFF);
        check("mult_neg_lo", lo, 32'hFFFF_FFEB);

        // MULT min * min = 2^62
        do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, lat, bcnt);
        check("mult_min_hi", hi, 32'h4000_0000);
        check("mult_min_lo", lo, 32'h0000_0000);

        // DIV -7 / 2
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, lat, bcnt);
        check("div_neg_lat", lat, 32'd33);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);
        check("div_neg_dbz", {31'd0, div_by_zero}, 32'd0);

        // DIV 7 / -2
        do_op(OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, lat, bcnt);
        check("div_negb_lo", lo, 32'hFFFF_FFFD);
        check("div_negb_hi", hi, 32'h0000_0001);

        // DIVU 100 / 7
        do_op(OP_DIVU, 32'd100, 32'd7, lat, bcnt);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        // DIV overflow case: min / -1
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0000_0000);

        // DIVU by zero
        do_op(OP_DIVU, 32'h0000_1234, 32'h0000_0000, lat, bcnt);
        check("divu_dz_lat", lat, DZ_LAT);
        check("divu_dz_busy", bcnt, DZ_LAT);
        check("divu_dz_hi", hi, 32'h0000_1234);
        check("divu_dz_lo", lo, 32'hFFFF_FFFF);
        check("divu_dz_flag", {31'd0, div_by_zero}, DZ_FLAG);

        // DIV by zero with a negative dividend keeps the signed value
        do_op(OP_DIV, 32'hFFFF_FFF0, 32'h0000_0000, lat, bcnt);
        check("div_dz_lat", lat, DZ_LAT);
        check("div_dz_hi", hi, 32'hFFFF_FFF0);
        check("div_dz_lo", lo, 32'hFFFF_FFFF);

        // The next accept clears the flag
        do_op(OP_DIVU, 32'd9, 32'd3, lat, bcnt);
        check("dbz_cleared", {31'd0, div_by_zero}, 32'd0);
        check("divu_9_3_lo", lo, 32'd3);
        check("divu_9_3_hi", hi, 32'd0);

        // Start while busy is ignored
        @(negedge clk);
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd6;
        b     = 32'd7;
        @(posedge clk);
        #1;
        start      = 1'b0;
        pulses     = 0;
        first_done = 0;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 10) begin
                start = 1'b1;
                op    = OP_DIVU;
                a     = 32'd9;
                b     = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                pulses++;
                if (first_done == 0) first_done = cyc;
            end
        end
        check("ignore_pulses", pulses, 32'd1);
        check("ignore_lat", first_done, 32'd33);
        check("ignore_hi", hi, 32'd0);
        check("ignore_lo", lo, 32'd42);

        // Asynchronous reset mid-calculation
        @(negedge clk);
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd5;
        b     = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        do_op(OP_MULTU, 32'd5, 32'd5, lat, bcnt);
        check("post_rst_lat", lat, 32'd33);
        check("post_rst_lo", lo, 32'd25);
        check("post_rst_hi", hi, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
